// File: rtl/uart_top_pkg.sv
// ----------------------------------------------------------------------------
// uart_top_pkg
// Shared constants, types and helpers for the host UART bridge.
//   - framing byte, packet/reply type codes, reply status codes
//   - parser state encodings (legacy 3-bit codes, also shown on debug_status)
//   - APP command codes
//   - reply record and CRC-16/CCITT-FALSE byte update (used when
//     UART_CRC_CHECK_EN is defined)
// ----------------------------------------------------------------------------
package uart_top_pkg;

    localparam logic [7:0] SOF = 8'h5A;

    // Packet types: host -> bridge, then bridge -> host replies.
    localparam logic [7:0] PKT_APP_CMD = 8'h01;
    localparam logic [7:0] PKT_ETH_RX  = 8'h10;
    localparam logic [7:0] PKT_APP_RSP = 8'h81;
    localparam logic [7:0] PKT_ETH_RSP = 8'h90;
    localparam logic [7:0] PKT_ERR_RSP = 8'hFF;

    typedef enum logic [7:0] {
        STAT_OK       = 8'h00,
        STAT_NOT_CONN = 8'h01,
        STAT_BAD_REQ  = 8'h02,
        STAT_LEN_ERR  = 8'h03,
        STAT_CRC_ERR  = 8'h04
    } status_t;

    // Parser states; the numeric codes are visible on debug_status[2:0].
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_TYPE     = 3'd1;
    localparam logic [2:0] ST_LEN_HI   = 3'd2;
    localparam logic [2:0] ST_LEN_LO   = 3'd3;
    localparam logic [2:0] ST_PAYLOAD  = 3'd4;
    localparam logic [2:0] ST_CRC_HI   = 3'd5;
    localparam logic [2:0] ST_CRC_LO   = 3'd6;
    localparam logic [2:0] ST_DISPATCH = 3'd7;

    localparam logic [15:0] CMD_CONNECT = 16'h0001;
    localparam logic [15:0] CMD_CLOSE   = 16'h0002;

    // Variable part of the fixed 8-byte reply: 5A rtype 00 02 p0 p1 crc.
    typedef struct packed {
        logic [7:0]  rtype;
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [15:0] crc;
    } reply_t;

    // CRC-16/CCITT-FALSE, poly 0x1021, MSB first, one byte per call.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                 input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_top_byte_phy.sv
// ----------------------------------------------------------------------------
// uart_byte_phy
// 8N1 byte-level UART PHY, LSB first, idle high.
//   RX: 2-flop synchronizer, falling-edge start detect, start bit re-checked
//       at BAUD_DIV/2, data and stop bits sampled every BAUD_DIV clocks.
//   TX: 10-bit shifter; a new byte may be accepted in the last clock of the
//       current stop bit so consecutive bytes leave with no idle gap.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   rx             raw serial input
//   rx_data        last received byte (valid with rx_valid)
//   rx_valid       1-cycle strobe, good byte received
//   rx_frame_err   1-cycle strobe, byte dropped because stop bit was 0
//   tx_start       load tx_data (honoured only while tx_ready)
//   tx_data        byte to send
//   tx_ready       shifter can take a byte this cycle
//   tx_busy        frame in flight
//   tx             serial output
// ----------------------------------------------------------------------------
module uart_byte_phy #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shreg;

    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shreg;

    // Synchronizer and edge history reset to the idle-high line level so a
    // reset never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shreg     <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A glitch shorter than half a bit is not a start bit.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_sync, rx_shreg[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin // RX_STOP
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) rx_valid     <= 1'b1;
                        else         rx_frame_err <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_data = rx_shreg;

    // Ready in the last clock of the stop bit lets the next start bit follow
    // immediately.
    assign tx_ready = !tx_busy || (tx_cnt == DIV_LAST && tx_bit == 4'd9);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            tx       <= 1'b1;
            tx_shreg <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (tx_start && tx_ready) begin
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            tx_shreg <= {1'b1, tx_data};
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == DIV_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    tx       <= tx_shreg[0];
                    tx_shreg <= {1'b1, tx_shreg[8:1]};
                    tx_bit   <= tx_bit + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_top.sv
// ----------------------------------------------------------------------------
// uart_top
// Host-facing UART bridge: deframes host packets
//   5A, TYPE, LEN_HI, LEN_LO, payload[LEN], CRC_HI, CRC_LO
// tracks the APP connection, counts DATA_WIDTH-bit beats of ETH_RX frames and
// answers each accepted packet with an 8-byte status reply on uart_tx.
// Optional feature macro: UART_CRC_CHECK_EN (CRC-16/CCITT-FALSE check of
// incoming packets and CRC on replies; otherwise CRC bytes are ignored and
// replies carry 00 00).
// Ports:
//   clk                single system clock
//   rst_n              synchronous reset, active-low
//   uart_rx            serial in, 8N1
//   uart_tx            serial out, 8N1
//   debug_status       {tx busy, crc err, len err, framing err, connected,
//                       parser state[2:0]}; error bits sticky until reset
//   connection_active  APP-level connection open
// ----------------------------------------------------------------------------
module uart_top
    import uart_top_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 50000000,
    parameter int MAX_LEN    = 1518
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] debug_status,
    output logic       connection_active
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int LW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TIMEOUT  = 160 * BAUD_DIV;   // 16 byte-times of silence
    localparam int TW       = $clog2(TIMEOUT);

    localparam logic [15:0]   MAX_LEN_W    = 16'(MAX_LEN);
    localparam logic [LW-1:0] LANE_LAST    = LW'(BYTES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;
    logic       phy_tx_start, phy_tx_ready, phy_tx_busy;
    logic [7:0] phy_tx_data;

    uart_byte_phy #(.BAUD_DIV(BAUD_DIV)) u_phy (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .tx_start     (phy_tx_start),
        .tx_data      (phy_tx_data),
        .tx_ready     (phy_tx_ready),
        .tx_busy      (phy_tx_busy),
        .tx           (uart_tx)
    );

    // ---------------------------------------------------------------- parser
    logic [2:0]    state;
    logic [7:0]    ptype;
    logic [15:0]   len, byte_cnt, cmd, beats;
    logic [LW-1:0] lane;
    logic [TW-1:0] idle_cnt;
    logic          conn, frame_err, len_err, crc_err;
    logic          crc_ok;
    logic [15:0]   len_next;

    assign len_next = {len[15:8], rx_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptype     <= '0;
            len       <= '0;
            byte_cnt  <= '0;
            cmd       <= '0;
            beats     <= '0;
            lane      <= '0;
            idle_cnt  <= '0;
            conn      <= 1'b0;
            frame_err <= 1'b0;
            len_err   <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            if (rx_frame_err) frame_err <= 1'b1;

            if (state == ST_IDLE || rx_valid) idle_cnt <= '0;
            else                              idle_cnt <= idle_cnt + 1'b1;

            // Abandon a stalled packet; a byte arriving this very cycle wins.
            if (state != ST_IDLE && state != ST_DISPATCH &&
                idle_cnt == TIMEOUT_LAST && !rx_valid) begin
                state <= ST_IDLE;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_data == SOF) state <= ST_TYPE;
                end
                ST_TYPE: begin
                    if (rx_valid) begin
                        ptype <= rx_data;
                        state <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_valid) begin
                        len[15:8] <= rx_data;
                        state     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_valid) begin
                        len[7:0] <= rx_data;
                        byte_cnt <= '0;
                        cmd      <= '0;
                        beats    <= '0;
                        lane     <= '0;
                        if (len_next > MAX_LEN_W) begin
                            len_err <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (len_next == 16'd0) begin
                            state <= ST_CRC_HI;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        if (byte_cnt == 16'd0) cmd[15:8] <= rx_data;
                        if (byte_cnt == 16'd1) cmd[7:0]  <= rx_data;
                        // A byte landing in lane 0 opens a new beat, so the
                        // count equals ceil(LEN/BYTES) with a padded tail.
                        if (lane == '0) beats <= beats + 16'd1;
                        lane <= (lane == LANE_LAST) ? '0 : lane + 1'b1;
                        if (byte_cnt == len - 16'd1) state <= ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (rx_valid) state <= ST_CRC_LO;
                end
                ST_CRC_LO: begin
                    if (rx_valid) state <= ST_DISPATCH;
                end
                default: begin // ST_DISPATCH
                    state <= ST_IDLE;
                    if (!crc_ok) begin
                        crc_err <= 1'b1;
                    end else if (ptype == PKT_APP_CMD && len >= 16'd2) begin
                        if (cmd == CMD_CONNECT)    conn <= 1'b1;
                        else if (cmd == CMD_CLOSE) conn <= 1'b0;
                    end
                end
            endcase
        end
    end

    // --------------------------------------------------------- reply builder
    logic [7:0]  rsp_rtype, rsp_p0;
    status_t     rsp_status;
    logic [15:0] rsp_crc;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rsp_rtype  = PKT_ERR_RSP;
        rsp_p0     = ptype;
        rsp_status = STAT_BAD_REQ;
        case (ptype)
            PKT_APP_CMD: begin
                rsp_rtype = PKT_APP_RSP;
                rsp_p0    = cmd[7:0];
                if (len >= 16'd2 && (cmd == CMD_CONNECT || cmd == CMD_CLOSE))
                    rsp_status = STAT_OK;
            end
            PKT_ETH_RX: begin
                rsp_rtype  = PKT_ETH_RSP;
                rsp_p0     = beats[7:0];
                rsp_status = conn ? STAT_OK : STAT_NOT_CONN;
            end
            default: ;
        endcase
        if (!crc_ok) rsp_status = STAT_CRC_ERR;
    end

`ifdef UART_CRC_CHECK_EN
    logic [15:0] crc_calc, crc_rx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_calc <= 16'hFFFF;
            crc_rx   <= '0;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: crc_calc <= 16'hFFFF;
                ST_TYPE, ST_LEN_HI, ST_LEN_LO, ST_PAYLOAD:
                    crc_calc <= crc16_update(crc_calc, rx_data);
                ST_CRC_HI: crc_rx[15:8] <= rx_data;
                ST_CRC_LO: crc_rx[7:0]  <= rx_data;
                default: ;
            endcase
        end
    end

    assign crc_ok  = (crc_calc == crc_rx);
    assign rsp_crc = crc16_update(crc16_update(crc16_update(crc16_update(
                     crc16_update(16'hFFFF, rsp_rtype), 8'h00), 8'h02),
                     rsp_p0), rsp_status);
`else
    assign crc_ok  = 1'b1;
    assign rsp_crc = 16'h0000;
`endif

    // ------------------------------------------------------- TX sequencing
    reply_t      pend;
    logic        pend_valid, tx_active;
    logic [3:0]  tx_left;
    logic [63:0] tx_frame;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend       <= '0;
            pend_valid <= 1'b0;
            tx_active  <= 1'b0;
            tx_left    <= '0;
            tx_frame   <= '0;
        end else begin
            if (!tx_active) begin
                if (pend_valid && phy_tx_ready) begin
                    tx_frame   <= {SOF, pend.rtype, 8'h00, 8'h02,
                                   pend.p0, pend.p1, pend.crc};
                    tx_left    <= 4'd8;
                    tx_active  <= 1'b1;
                    pend_valid <= 1'b0;
                end
            end else if (phy_tx_ready) begin
                // Ready with nothing left means the final stop bit is ending.
                if (tx_left == 4'd0) begin
                    tx_active <= 1'b0;
                end else begin
                    tx_frame <= {tx_frame[55:0], 8'h00};
                    tx_left  <= tx_left - 4'd1;
                end
            end
            // Placed last: a fresh reply overwrites one that never started,
            // even in the cycle the old one is being taken.
            if (state == ST_DISPATCH) begin
                pend       <= '{rtype: rsp_rtype, p0: rsp_p0,
                                p1: rsp_status, crc: rsp_crc};
                pend_valid <= 1'b1;
            end
        end
    end

    assign phy_tx_start = tx_active && phy_tx_ready && (tx_left != 4'd0);
    assign phy_tx_data  = tx_frame[63:56];

    assign connection_active = conn;
    assign debug_status = {tx_active | phy_tx_busy, crc_err, len_err,
                           frame_err, conn, state};

endmodule

// File: tb/tb_uart_top.sv
// ----------------------------------------------------------------------------
// tb_uart_top
// Directed bench for uart_top with a fast baud divisor (8 clocks per bit).
// A background monitor decodes uart_tx into a byte queue; the main sequence
// sends host packets and compares each reply and status output against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_uart_top;

    localparam int BIT = 8;   // CLK_FREQ / BAUD_RATE below

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic       uart_tx;
    logic [7:0] debug_status;
    logic       connection_active;

    int compared   = 0;
    int mismatched = 0;
    int tx_stop_bad = 0;

    logic [7:0] txq[$];
    logic [7:0] pkt[$];

    uart_top #(
        .DATA_WIDTH (64),
        .BAUD_RATE  (115200),
        .CLK_FREQ   (921600),
        .MAX_LEN    (1518)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uart_rx           (uart_rx),
        .uart_tx           (uart_tx),
        .debug_status      (debug_status),
        .connection_active (connection_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Serial decoder for uart_tx: sample mid-bit on the falling clock edge.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (BIT) @(negedge clk);
            if (uart_tx !== 1'b1) tx_stop_bad++;
            txq.push_back(b);
        end
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = !bad_stop;
        repeat (BIT) @(negedge clk);
        if (bad_stop) begin
            uart_rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_pkt();
        while (pkt.size() > 0) send_byte(pkt.pop_front(), 1'b0);
    endtask

    task automatic app_pkt(input logic [15:0] cmd);
        pkt = '{8'h5A, 8'h01, 8'h00, 8'h02, cmd[15:8], cmd[7:0], 8'h00, 8'h00};
        send_pkt();
    endtask

    task automatic eth_pkt(input int len);
        logic [15:0] l;
        l = 16'(len);
        pkt = '{8'h5A, 8'h10, l[15:8], l[7:0]};
        for (int i = 0; i < len; i++) pkt.push_back(8'(i * 7 + 3));
        pkt.push_back(8'h00);
        pkt.push_back(8'h00);
        send_pkt();
    endtask

    // Wait (bounded) for 8 reply bytes and compare them as one 64-bit word.
    task automatic expect_reply(input string tag, input logic [63:0] expected);
        logic [63:0] got;
        int t;
        t = 0;
        while (txq.size() < 8 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        got = '0;
        for (int i = 0; i < 8; i++) begin
            got = {got[55:0], (txq.size() > 0) ? txq.pop_front() : 8'hxx};
        end
        check(tag, got, expected);
        repeat (20) @(negedge clk);
    endtask

    initial begin : main
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: idle after reset
        check("reset uart_tx", 64'(uart_tx), 64'h1);
        check("reset connection_active", 64'(connection_active), 64'h0);
        check("reset debug_status", 64'(debug_status), 64'h00);

        // 2: CONNECT
        app_pkt(16'h0001);
        expect_reply("connect reply", 64'h5A81_0002_0100_0000);
        check("connect active", 64'(connection_active), 64'h1);
        check("connect debug", 64'(debug_status), 64'h08);

        // 3: ETH_RX while connected, 74 and 90 bytes
        eth_pkt(74);
        expect_reply("eth74 reply", 64'h5A90_0002_0A00_0000);
        eth_pkt(90);
        expect_reply("eth90 reply", 64'h5A90_0002_0C00_0000);

        // Unknown command, LEN=0 APP packet, unknown type
        app_pkt(16'h0007);
        expect_reply("bad cmd reply", 64'h5A81_0002_0702_0000);
        check("bad cmd keeps conn", 64'(connection_active), 64'h1);
        pkt = '{8'h5A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt();
        expect_reply("app len0 reply", 64'h5A81_0002_0002_0000);
        pkt = '{8'h5A, 8'h22, 8'h00, 8'h01, 8'hAB, 8'h00, 8'h00};
        send_pkt();
        expect_reply("unknown type reply", 64'h5AFF_0002_2202_0000);

        // 4: CLOSE, then ETH_RX while closed
        app_pkt(16'h0002);
        expect_reply("close reply", 64'h5A81_0002_0200_0000);
        check("close active", 64'(connection_active), 64'h0);
        eth_pkt(8);
        expect_reply("eth8 closed reply", 64'h5A90_0002_0101_0000);

        // 5: junk, framing error, oversize length
        send_byte(8'h33, 1'b0);
        send_byte(8'h5A, 1'b1);
        pkt = '{8'h5A, 8'h10, 8'h07, 8'h00};
        send_pkt();
        repeat (1500) @(negedge clk);
        check("error seq no reply", 64'(txq.size()), 64'h0);
        check("error seq debug", 64'(debug_status), 64'h30);
        app_pkt(16'h0001);
        expect_reply("reconnect reply", 64'h5A81_0002_0100_0000);
        check("reconnect debug", 64'(debug_status), 64'h38);

        // Inter-byte timeout returns the parser to IDLE without a reply
        pkt = '{8'h5A, 8'h01};
        send_pkt();
        repeat (10) @(negedge clk);
        check("stalled in LEN_HI", 64'(debug_status), 64'h3A);
        repeat (1400) @(negedge clk);
        check("timeout to idle", 64'(debug_status), 64'h38);
        check("timeout no reply", 64'(txq.size()), 64'h0);

        // 6: reset in the middle of a payload byte
        pkt = '{8'h5A, 8'h10, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33};
        send_pkt();
        uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid reset debug", 64'(debug_status), 64'h00);
        check("mid reset uart_tx", 64'(uart_tx), 64'h1);
        check("mid reset connection", 64'(connection_active), 64'h0);
        app_pkt(16'h0001);
        expect_reply("post reset connect", 64'h5A81_0002_0100_0000);
        check("post reset active", 64'(connection_active), 64'h1);

        check("tx stop bits", 64'(tx_stop_bad), 64'h0);
        check("no stray tx bytes", 64'(txq.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
